// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: program-loader front end.
// Packs field-level instruction requests into 20-bit instruction words and writes them,
// through a small FIFO, sequentially into instruction memory from a programmable base.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, base_addr,       begin a load (IDLE only); base and request count sampled on start
//   num_words
//   req_valid/req_ready     request handshake
//   req_class, req_fn,      request fields: class, ALU/shift/memory fn, rd, rs, rt, immediate
//   req_rd, req_rs,
//   req_rt, req_imm
//   imem_we, imem_ready,    registered memory write port; holds while imem_ready is low
//   imem_addr, imem_wdata
//   busy, done, err         status: not idle, one-cycle completion pulse, sticky illegal request
module instr_encoder_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_class,
  input  logic [2:0]        req_fn,
  input  logic [2:0]        req_rd,
  input  logic [2:0]        req_rs,
  input  logic [2:0]        req_rt,
  input  logic [7:0]        req_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [19:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Opcode prefixes and memory fn codes shared with the instruction decoder.
  localparam logic [1:0] REGISTER_TYPE_OPCODE  = 2'b00;
  localparam logic [1:0] IMMEDIATE_TYPE_OPCODE = 2'b01;
  localparam logic [2:0] SHIFT_TYPE_OPCODE     = 3'b100;
  localparam logic [2:0] MEMORY_TYPE_OPCODE    = 3'b101;
  localparam logic [1:0] STM_FN                = 2'b00;
  localparam logic [1:0] LDM_FN                = 2'b01;

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [ADDR_W:0]     acc_q, acc_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                err_q, err_d;

  logic [19:0]         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       cnt_q, cnt_d;

  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [19:0]         imem_wdata_q, imem_wdata_d;

  logic [5:0]          enc_op;
  logic [7:0]          enc_pl;
  logic [19:0]         enc_word;
  logic                req_illegal;
  logic                fifo_full;
  logic                fifo_empty;
  logic                hs;
  logic                push;
  logic                pop;

  // Field packing.
  always_comb begin
    enc_op = '0;
    enc_pl = '0;
    unique case (req_class)
      2'd0: begin
        enc_op = {REGISTER_TYPE_OPCODE, req_fn, 1'b0};
        enc_pl = {req_rt, 5'b0};
      end
      2'd1: begin
        enc_op = {IMMEDIATE_TYPE_OPCODE, req_fn, 1'b0};
        enc_pl = req_imm;
      end
      2'd2: begin
        enc_op = {SHIFT_TYPE_OPCODE, req_fn[1:0], 1'b0};
        enc_pl = {3'b000, req_imm[4:0]};
      end
      default: begin
        enc_op = {MEMORY_TYPE_OPCODE, req_fn[1:0], 1'b0};
        enc_pl = req_imm;
      end
    endcase
  end

  assign enc_word    = {enc_op, req_rd, req_rs, enc_pl};
  assign req_illegal = (req_class == 2'd3) && (req_fn[1:0] != STM_FN) && (req_fn[1:0] != LDM_FN);

  assign fifo_full  = (cnt_q == (PtrW+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  assign req_ready = (state_q == StLoad) && !fifo_full && (acc_q < num_q);
  assign hs        = req_valid && req_ready;
  // Illegal requests complete the handshake but never enter the FIFO.
  assign push      = hs && !req_illegal;
  // The output register takes the FIFO head when idle or when its word is being accepted.
  assign pop       = !fifo_empty && (!imem_we_q || imem_ready);

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    acc_d        = acc_q;
    next_addr_d  = next_addr_q;
    err_d        = err_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    imem_we_d    = imem_we_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    // FIFO bookkeeping.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // Write-port register.
    if (pop) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = next_addr_q;
      imem_wdata_d = mem_q[rd_ptr_q];
      next_addr_d  = next_addr_q + ADDR_W'(1);
    end else if (imem_we_q && imem_ready) begin
      imem_we_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d       = 1'b0;
          num_d       = num_words;
          acc_d       = '0;
          next_addr_d = base_addr;
          state_d     = (num_words == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (hs) begin
          acc_d = acc_q + (ADDR_W+1)'(1);
          if (req_illegal) err_d = 1'b1;
        end
        if (acc_q == num_q) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty && !imem_we_q) state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      num_q        <= '0;
      acc_q        <= '0;
      next_addr_q  <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      acc_q        <= acc_d;
      next_addr_q  <= next_addr_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign err        = err_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Reverse direction of the instruction controller: packs field-level instruction requests (class, fn, register indices, immediate) into 20-bit instruction words using the same opcode macros from defines.sv. Encoded words are buffered and written sequentially into instruction memory from a programmable base address. The block is the program-loader front end used by the testbench and the boot path before the core leaves reset.

Parameters:
ADDR_W, 8, instruction-memory address width; the address counter wraps modulo 2^ADDR_W.
FIFO_DEPTH, 4, encoded-word buffer depth; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  one-cycle pulse that begins a load; ignored unless the FSM is in IDLE.
base_addr  in  ADDR_W  first write address; sampled on start.
num_words  in  ADDR_W+1  number of requests to accept; sampled on start.
req_valid  in  1  request valid.
req_ready  out  1  request ready; a request transfers when req_valid && req_ready.
req_class  in  2  0=register, 1=immediate, 2=shift, 3=memory.
req_fn  in  3  ALU fn for register/immediate; [1:0] for shift and memory.
req_rd  in  3  destination register.
req_rs  in  3  source register 1.
req_rt  in  3  source register 2; register class only.
req_imm  in  8  immediate for immediate/memory class; [4:0] is the shift count for shift class.
imem_we  out  1  write valid.
imem_ready  in  1  memory accepts the write this cycle.
imem_addr  out  ADDR_W  write address.
imem_wdata  out  20  encoded instruction word.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a load completes.
err  out  1  sticky illegal-request flag; cleared on an accepted start.

Behaviour:
- Word layout: [19:14] opcode, [13:11] rd, [10:8] rs, [7:0] payload.
- Opcode and payload by class (opcode bit 0 is always 0):
  - Register: opcode = {REGISTER_TYPE_OPCODE, fn[2:0], 0}; payload = {rt, 5'b0}.
  - Immediate: opcode = {IMMEDIATE_TYPE_OPCODE, fn[2:0], 0}; payload = imm.
  - Shift: opcode = {SHIFT_TYPE_OPCODE, fn[1:0], 0}; payload = {3'b0, imm[4:0]}.
  - Memory: opcode = {MEMORY_TYPE_OPCODE, fn[1:0], 0}; payload = imm.
- Illegal request: memory class with fn[1:0] equal to neither STM_FN nor LDM_FN.
  - The handshake still completes and the request counts toward num_words.
  - The word is not written and the address does not advance.
  - err is set and stays set.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: req_ready=0. On start with num_words=0, go to DONE. On start with num_words>0, go to LOAD.
  - LOAD: req_ready = !fifo_full && (accepted < num_words). When the accepted count reaches num_words, go to DRAIN on the next cycle.
  - DRAIN: req_ready=0. Once the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Encode and push happen in the handshake cycle; there is one cycle of registered FIFO write.
- Write port:
  - imem_we, imem_addr and imem_wdata are registered.
  - A write completes on any cycle with imem_we && imem_ready.
  - While imem_ready=0, all three outputs hold stable.
  - After each completed write the address increments, wrapping from 2^ADDR_W-1 to 0.
  - The next FIFO head loads in the same cycle, so back-to-back writes run at one word per cycle.
- Latency: a request accepted at cycle N into an empty FIFO with imem_ready=1 gives imem_we=1 at N+2. Throughput is one word per cycle.
- FIFO boundaries:
  - Full: req_ready=0.
  - Simultaneous push and pop when full: pop frees a slot the next cycle; no same-cycle pass-through.
  - Empty: imem_we=0 after the current write completes.
- start while busy is ignored and does not change err.
- Reset values: req_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, FIFO empty, FSM in IDLE.
- Reset asserted mid-load: all state is discarded on that edge, any pending write is dropped, and imem_we is 0 on the next cycle.

Test Plan:
- Register encode: start base=0x10 num=1; class=0 fn=3 rd=1 rs=2 rt=5 -> a single imem write at addr 0x10, wdata={REGISTER_TYPE_OPCODE,3'd3,0,3'd1,3'd2,3'd5,5'd0}; then done pulse, err=0.
- Streaming: num=6, req_valid held high, imem_ready=1 -> req_valid/ready handshakes every cycle; addrs base..base+5 consecutive; done exactly once; busy low the cycle after done.
- Backpressure: imem_ready=0 for 10 cycles with num=8 -> exactly FIFO_DEPTH+1 words accepted, then req_ready=0; imem outputs stable; after release all 8 words are written in order, none lost or duplicated.
- Wrap: ADDR_W=8, base=0xFE, num=3 -> writes land at 0xFE, 0xFF, 0x00.
- Illegal memory fn: num=3 with the middle request class=3 and fn[1:0] not STM/LDM -> 2 writes at base and base+1; err=1 until the next start; done still pulses.
- Reset mid-load: rst_n low for 1 cycle during LOAD with 2 words buffered -> imem_we=0 next cycle, busy=0, err=0; a following num=0 start -> done pulse one cycle later and no writes.
